// File: rtl/sar_conv_sequencer.sv
`timescale 1ns/1ps
// SAR ADC conversion sequencer: walks the enabled channels, runs the track/hold
// window and the SAR start/done handshake, optionally averages, and publishes results.
module sar_conv_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int RES_BITS       = 12,
    parameter int SAMPLE_CYCLES  = 4,
    parameter int AVG_LOG2       = 0,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic [CH_W-1:0]     ch_sel,
    output logic                sample_en,
    output logic                sar_start,
    input  logic                sar_done,
    input  logic [RES_BITS-1:0] sar_result,
    output logic [RES_BITS-1:0] res_data,
    output logic [CH_W-1:0]     res_ch,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err,
    output logic [2:0]          state_dbg
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_SAMPLE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_PUBLISH = 3'd4;

    localparam int ACC_W = RES_BITS + AVG_LOG2;
    localparam int SC_W  = $clog2(SAMPLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AC_W  = AVG_LOG2 + 1;

    localparam logic [SC_W-1:0] SAMP_LAST = SC_W'(SAMPLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AC_W-1:0] AVG_LAST  = AC_W'((1 << AVG_LOG2) - 1);

    logic [2:0]        state;
    logic [SC_W-1:0]   samp_cnt;
    logic [TO_W-1:0]   tmo_cnt;
    logic [AC_W-1:0]   conv_cnt;
    logic [ACC_W-1:0]  acc;
    logic [NUM_CH-1:0] pending;

    logic [NUM_CH-1:0] adv_mask;
    logic              adv_go;
    logic [CH_W-1:0]   adv_ch;
    logic [2:0]        adv_state;

    function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Where to go once a channel is finished (published or timed out):
    // remaining channels first, then a fresh sweep if continuous, else idle.
    always_comb begin
        adv_mask = pending;
        adv_go   = 1'b1;
        if (pending == '0) begin
            if (continuous && (ch_mask != '0)) adv_mask = ch_mask;
            else                               adv_go   = 1'b0;
        end
        adv_ch    = adv_go ? lowest_idx(adv_mask) : ch_sel;
        adv_state = adv_go ? S_SELECT : S_IDLE;
    end

    assign sample_en = (state == S_SAMPLE);
    assign sar_start = (state == S_CONVERT) && (tmo_cnt == '0);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Output handshake: a result transfers on a clock edge where res_valid and
    // res_ready are both high; res_data/res_ch hold until then. A PUBLISH on the
    // transfer edge reloads the register (no overrun); a PUBLISH while the old
    // result is still unaccepted overwrites it and sets the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            samp_cnt    <= '0;
            tmo_cnt     <= '0;
            conv_cnt    <= '0;
            acc         <= '0;
            pending     <= '0;
            ch_sel      <= '0;
            res_data    <= '0;
            res_ch      <= '0;
            res_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (res_valid && res_ready) res_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        pending     <= ch_mask;
                        ch_sel      <= lowest_idx(ch_mask);
                        overrun     <= 1'b0;
                        timeout_err <= 1'b0;
                        state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    pending  <= pending & ~(NUM_CH'(1) << ch_sel);
                    acc      <= '0;
                    conv_cnt <= '0;
                    samp_cnt <= '0;
                    state    <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (samp_cnt == SAMP_LAST) begin
                        samp_cnt <= '0;
                        tmo_cnt  <= '0;
                        state    <= S_CONVERT;
                    end else begin
                        samp_cnt <= samp_cnt + SC_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (sar_done) begin
                        acc <= acc + ACC_W'(sar_result);
                        if (conv_cnt == AVG_LAST) begin
                            state <= S_PUBLISH;
                        end else begin
                            conv_cnt <= conv_cnt + AC_W'(1);
                            state    <= S_SAMPLE;
                        end
                    end else if (tmo_cnt == TO_LAST) begin
                        // Abandon this channel without publishing anything.
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        pending     <= adv_mask;
                        ch_sel      <= adv_ch;
                        state       <= adv_state;
                    end else begin
                        tmo_cnt <= tmo_cnt + TO_W'(1);
                    end
                end
                S_PUBLISH: begin
                    res_data  <= RES_BITS'(acc >> AVG_LOG2);
                    res_ch    <= ch_sel;
                    res_valid <= 1'b1;
                    if (res_valid && !res_ready) overrun <= 1'b1;
                    pending   <= adv_mask;
                    ch_sel    <= adv_ch;
                    state     <= adv_state;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
`timescale 1ns/1ps
// Bench for sar_conv_sequencer: a SAR model feeds queued conversion values, a
// scoreboard checks each accepted result; a second instance covers averaging.
module tb_sar_conv_sequencer;

    localparam int NUM_CH = 4;
    localparam int RES_BITS = 12;
    localparam int SC = 4;
    localparam int TO = 64;
    localparam int CH_W = 2;
    localparam int W = CH_W + RES_BITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance (no averaging) ----------------
    logic                start, continuous, sar_done, res_ready;
    logic [NUM_CH-1:0]   ch_mask;
    logic [RES_BITS-1:0] sar_result, res_data;
    logic [CH_W-1:0]     ch_sel, res_ch;
    logic                sample_en, sar_start, res_valid, busy, overrun, timeout_err;
    logic [2:0]          state_dbg;

    sar_conv_sequencer #(.NUM_CH(NUM_CH), .RES_BITS(RES_BITS), .SAMPLE_CYCLES(SC),
                         .AVG_LOG2(0), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .ch_sel(ch_sel), .sample_en(sample_en), .sar_start(sar_start),
        .sar_done(sar_done), .sar_result(sar_result), .res_data(res_data), .res_ch(res_ch),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // ---------------- averaging instance (4 conversions per channel) ----------------
    logic                a_start, a_continuous, a_sar_done, a_res_ready;
    logic [NUM_CH-1:0]   a_ch_mask;
    logic [RES_BITS-1:0] a_sar_result, a_res_data;
    logic [CH_W-1:0]     a_ch_sel, a_res_ch;
    logic                a_sample_en, a_sar_start, a_res_valid, a_busy, a_overrun, a_timeout_err;
    logic [2:0]          a_state_dbg;

    sar_conv_sequencer #(.NUM_CH(NUM_CH), .RES_BITS(RES_BITS), .SAMPLE_CYCLES(SC),
                         .AVG_LOG2(2), .TIMEOUT_CYCLES(TO)) dut_avg (
        .clk(clk), .reset(reset), .start(a_start), .continuous(a_continuous),
        .ch_mask(a_ch_mask), .ch_sel(a_ch_sel), .sample_en(a_sample_en), .sar_start(a_sar_start),
        .sar_done(a_sar_done), .sar_result(a_sar_result), .res_data(a_res_data), .res_ch(a_res_ch),
        .res_valid(a_res_valid), .res_ready(a_res_ready), .busy(a_busy), .overrun(a_overrun),
        .timeout_err(a_timeout_err), .state_dbg(a_state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0]        exp_q[$];
    logic [CH_W-1:0]     ch_q[$];
    logic [RES_BITS-1:0] val_q[$];
    logic [W-1:0]        a_exp_q[$];
    logic [CH_W-1:0]     a_ch_q[$];
    logic [RES_BITS-1:0] a_val_q[$];
    int   mute_ch = -1;
    int   fixed_dly = 10;
    int   a_starts = 0;
    bit   rdy_rand = 1'b0;
    logic rdy_val = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_conv(input int c, input logic [RES_BITS-1:0] v);
        ch_q.push_back(CH_W'(c));
        if (c != mute_ch) begin
            val_q.push_back(v);
            exp_q.push_back({CH_W'(c), v});
        end
    endtask

    task automatic queue_sweep(input logic [NUM_CH-1:0] m);
        for (int c = 0; c < NUM_CH; c++)
            if (m[c]) push_conv(c, RES_BITS'($urandom_range(0, 4095)));
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] m);
        @(posedge clk); #1;
        ch_mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((busy || res_valid || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            expired(name);
            exp_q.delete(); ch_q.delete(); val_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ch_sel"}, ch_sel, 0);
        check({tag, "_sample_en"}, sample_en, 0);
        check({tag, "_sar_start"}, sar_start, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_ch"}, res_ch, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_state_dbg"}, state_dbg, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete(); ch_q.delete(); val_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("post_reset");
    endtask

    task automatic avg_sweep(input logic [NUM_CH-1:0] m, input bit directed);
        int sum;
        int n = 0;
        logic [RES_BITS-1:0] v;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                sum = 0;
                for (int j = 0; j < 4; j++) begin
                    v = directed ? RES_BITS'(100 + j) : RES_BITS'($urandom_range(0, 4095));
                    a_ch_q.push_back(CH_W'(c));
                    a_val_q.push_back(v);
                    sum += int'(v);
                end
                a_exp_q.push_back({CH_W'(c), RES_BITS'(sum / 4)});
            end
        end
        @(posedge clk); #1;
        a_ch_mask = m;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        while ((a_busy || a_res_valid || a_exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            expired("avg_sweep_done");
            a_exp_q.delete(); a_ch_q.delete(); a_val_q.delete();
        end
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        int low_run = 0;
        res_ready = rdy_val;
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) begin
                res_ready = ($urandom_range(0, 3) != 0) || (low_run >= 3);
                low_run = res_ready ? 0 : low_run + 1;
            end else begin
                res_ready = rdy_val;
            end
        end
    end

    // ---------------- SAR model, main instance ----------------
    initial begin
        logic [CH_W-1:0]     c;
        logic [RES_BITS-1:0] v;
        int d;
        bit aborted;
        sar_done = 1'b0;
        sar_result = '0;
        forever begin
            @(negedge clk);
            if (!reset && sar_start) begin
                if (ch_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sar_start_unexpected: ch_sel=%0d (t=%0t)", ch_sel, $time);
                end else begin
                    c = ch_q.pop_front();
                    check("conv_ch", ch_sel, c);
                    if (int'(c) == mute_ch) begin
                        for (int n = 1; n <= TO; n++) begin
                            @(negedge clk);
                            if (n == TO - 1) check("timeout_early", timeout_err, 0);
                            if (n == TO) check("timeout_err_set", timeout_err, 1);
                        end
                    end else begin
                        v = val_q.pop_front();
                        d = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 20);
                        aborted = 1'b0;
                        repeat (d) begin
                            @(posedge clk);
                            if (reset) aborted = 1'b1;
                        end
                        if (!aborted && !reset) begin
                            #1;
                            sar_done = 1'b1;
                            sar_result = v;
                            @(posedge clk); #1;
                            sar_done = 1'b0;
                            @(negedge clk);
                            @(negedge clk);
                            if (!reset) check("res_valid_latency", res_valid, 1);
                        end
                    end
                end
            end
        end
    end

    // ---------------- SAR model, averaging instance ----------------
    initial begin
        logic [CH_W-1:0] c;
        a_sar_done = 1'b0;
        a_sar_result = '0;
        forever begin
            @(negedge clk);
            if (!reset && a_sar_start) begin
                a_starts++;
                if (a_ch_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL avg_sar_start_unexpected: ch_sel=%0d (t=%0t)", a_ch_sel, $time);
                end else begin
                    c = a_ch_q.pop_front();
                    check("avg_conv_ch", a_ch_sel, c);
                    repeat (3) @(posedge clk);
                    #1;
                    a_sar_done = 1'b1;
                    a_sar_result = a_val_q.pop_front();
                    @(posedge clk); #1;
                    a_sar_done = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard monitors ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL res_unexpected: ch=%0d data=0x%0h (t=%0t)", res_ch, res_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("res_ch", res_ch, e[W-1:RES_BITS]);
                    check("res_data", res_data, e[RES_BITS-1:0]);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && a_res_valid && a_res_ready) begin
                if (a_exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL avg_res_unexpected: ch=%0d data=0x%0h (t=%0t)", a_res_ch, a_res_data, $time);
                end else begin
                    e = a_exp_q.pop_front();
                    check("avg_res_ch", a_res_ch, e[W-1:RES_BITS]);
                    check("avg_res_data", a_res_data, e[RES_BITS-1:0]);
                end
            end
        end
    end

    // ---------------- pulse-shape checker ----------------
    initial begin
        int se_w = 0;
        logic [CH_W-1:0] se_ch = '0;
        logic prev_ss = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                se_w = 0;
                prev_ss = 1'b0;
            end else begin
                if (sample_en) begin
                    if (se_w == 0) se_ch = ch_sel;
                    else           check("ch_sel_stable", ch_sel, se_ch);
                    se_w++;
                end else if (se_w != 0) begin
                    check("sample_en_width", se_w, SC);
                    se_w = 0;
                end
                if (sar_start) begin
                    check("sar_start_width", prev_ss, 0);
                    check("sample_en_in_convert", sample_en, 0);
                end
                prev_ss = sar_start;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] last;
        int n;
        start = 1'b0; continuous = 1'b0; ch_mask = '0;
        a_start = 1'b0; a_continuous = 1'b0; a_ch_mask = '0; a_res_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        check("avg_reset_busy", a_busy, 0);
        check("avg_reset_valid", a_res_valid, 0);
        check("avg_reset_state_dbg", a_state_dbg, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed sweep: ch1 then ch3, SAR answers 10 cycles after sar_start.
        push_conv(1, 12'h123);
        push_conv(3, 12'hABC);
        do_start(4'b1010);
        for (int k = 1; k <= 2 + SC; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("lat_busy", busy, 1);
                check("lat_select_ch", ch_sel, 1);
                check("lat_select_no_sample", sample_en, 0);
            end
            if (k == 2) check("lat_sample_start", sample_en, 1);
            if (k == 1 + SC) begin
                check("lat_sample_end", sample_en, 1);
                check("lat_no_early_start", sar_start, 0);
            end
            if (k == 2 + SC) check("lat_sar_start", sar_start, 1);
        end
        // start with a wider mask mid-sweep must be ignored
        do_start(4'b1111);
        wait_drain("sweep_1010");
        check("sweep_1010_busy_low", busy, 0);

        // start with an empty mask does nothing
        do_start(4'b0000);
        repeat (5) begin
            @(negedge clk);
            check("mask0_busy", busy, 0);
        end

        // Reset while converting, then a normal sweep
        queue_sweep(4'b0101);
        do_start(4'b0101);
        n = 0;
        while (!sar_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) expired("reset_wait_convert");
        repeat (3) @(posedge clk);
        do_reset();
        repeat (20) begin
            @(negedge clk);
            check("post_reset_no_valid", res_valid, 0);
        end
        queue_sweep(4'b0101);
        do_start(4'b0101);
        wait_drain("post_reset_sweep");

        // Randomized sweeps with random SAR latency and a stalling consumer
        fixed_dly = 0;
        rdy_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [NUM_CH-1:0] m;
            m = NUM_CH'($urandom_range(1, 15));
            queue_sweep(m);
            do_start(m);
            wait_drain("random_sweep");
        end
        check("random_no_overrun", overrun, 0);

        // Timeout: ch2 never answers
        mute_ch = 2;
        queue_sweep(4'b0111);
        do_start(4'b0111);
        wait_drain("timeout_sweep");
        check("timeout_sticky", timeout_err, 1);
        mute_ch = -1;
        queue_sweep(4'b1000);
        do_start(4'b1000);
        check("timeout_cleared_on_start", timeout_err, 0);
        wait_drain("after_timeout_sweep");

        // Continuous sweeps with a stalled consumer
        rdy_rand = 1'b0;
        rdy_val = 1'b0;
        queue_sweep(4'b0011);
        queue_sweep(4'b0011);
        continuous = 1'b1;
        do_start(4'b0011);
        n = 0;
        while (!res_valid && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) expired("cont_first_result");
        check("cont_no_overrun_first", overrun, 0);
        n = 0;
        while (!overrun && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) expired("cont_overrun");
        check("cont_overrun_ch", res_ch, 1);
        n = 0;
        while (ch_q.size() > 1 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) expired("cont_second_sweep");
        @(posedge clk); #1 continuous = 1'b0;
        n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) expired("cont_to_idle");
        check("cont_queue_used", ch_q.size(), 0);
        check("cont_overrun_sticky", overrun, 1);
        check("cont_valid_held", res_valid, 1);
        if (exp_q.size() != 0) begin
            last = exp_q[$];
            check("cont_newest_ch", res_ch, last[W-1:RES_BITS]);
            check("cont_newest_data", res_data, last[RES_BITS-1:0]);
            exp_q.delete();
            exp_q.push_back(last);
        end
        rdy_val = 1'b1;
        wait_drain("cont_drain");
        queue_sweep(4'b0001);
        do_start(4'b0001);
        check("overrun_cleared_on_start", overrun, 0);
        wait_drain("after_cont_sweep");

        // Averaging instance: 100..103 -> 101, then random sweeps
        a_starts = 0;
        avg_sweep(4'b0001, 1'b1);
        check("avg_start_count", a_starts, 4);
        for (int i = 0; i < 3; i++) avg_sweep(NUM_CH'($urandom_range(1, 15)), 1'b0);
        check("avg_no_overrun", a_overrun, 0);
        check("avg_no_timeout", a_timeout_err, 0);
        check("avg_sample_idle", a_sample_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_conv_sequencer.md
Name: sar_conv_sequencer

Overview:
Sequences conversions of the SAR ADC logic block: selects the analog channel, runs the track/hold sample window, pulses the SAR start and waits for conversion-done. It optionally averages 2^AVG_LOG2 conversions per channel and presents each result through a one-entry valid/ready output register. It sits between the top-level pin wrapper (config/trigger from `ui_in`/`uio_in`) and the `sarlogic` datapath.

Parameters:
- NUM_CH, 4, number of analog channels; CH_W = max(1, clog2(NUM_CH)).
- RES_BITS, 12, SAR result width.
- SAMPLE_CYCLES, 4, cycles `sample_en` is held high before each conversion; minimum 1.
- AVG_LOG2, 0, log2 of conversions averaged per channel; 0 = no averaging.
- TIMEOUT_CYCLES, 64, maximum CONVERT cycles allowed before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  sweep trigger; sampled high in IDLE starts a sweep.
- continuous  in  1  1 = restart sweep automatically after the last channel.
- ch_mask  in  NUM_CH  enabled channels; latched at sweep start.
- ch_sel  out  CH_W  analog mux select.
- sample_en  out  1  track/hold switch enable.
- sar_start  out  1  one-cycle conversion start pulse to SAR.
- sar_done  in  1  SAR conversion complete strobe.
- sar_result  in  RES_BITS  SAR result; valid when `sar_done`=1.
- res_data  out  RES_BITS  averaged result.
- res_ch  out  CH_W  channel of `res_data`.
- res_valid  out  1  output register holds an unread result.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: a result was overwritten unread.
- timeout_err  out  1  sticky: a conversion timed out.

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE. All outputs 0: `ch_sel`, `sample_en`, `sar_start`, `res_data`, `res_ch`, `res_valid`, `busy`, `overrun`, `timeout_err`. Accumulator, counters and latched mask cleared. Reset mid-conversion abandons the conversion with no output.
- States: IDLE, SELECT, SAMPLE, CONVERT, PUBLISH.
- IDLE:
  - On `start`=1 with `ch_mask`!=0: latch the mask, clear `overrun` and `timeout_err`, go to SELECT.
  - `start` with mask=0 is ignored.
  - `start` outside IDLE is ignored.
- SELECT (1 cycle):
  - `ch_sel` = lowest-index unvisited latched channel (ascending order).
  - Clear the accumulator and sample count.
  - Go to SAMPLE.
- SAMPLE:
  - `sample_en`=1 for exactly SAMPLE_CYCLES cycles.
  - `ch_sel` stable throughout.
  - Then go to CONVERT.
- CONVERT:
  - `sar_start`=1 on the first cycle only; `sample_en`=0.
  - Timeout counter counts CONVERT cycles.
  - On a clock edge with `sar_done`=1: acc += `sar_result` (acc width RES_BITS+AVG_LOG2, no overflow possible).
    - If fewer than 2^AVG_LOG2 samples are taken: go to SAMPLE, same channel.
    - Otherwise go to PUBLISH.
  - `sar_done` during SAMPLE/SELECT/IDLE is ignored.
  - If TIMEOUT_CYCLES elapse without `sar_done`: set `timeout_err`, discard the accumulator, skip the channel (no output), advance as from PUBLISH.
- PUBLISH (1 cycle):
  - Output register loads `res_data`=acc>>AVG_LOG2 (truncating), `res_ch`=`ch_sel`, `res_valid`=1.
  - If `res_valid` was already 1 and not accepted this cycle: overwrite and set `overrun`.
  - Next state:
    - SELECT if channels remain.
    - Else SELECT with a freshly latched mask if `continuous`=1 and `ch_mask`!=0.
    - Else IDLE.
- Output handshake:
  - Transfer occurs on an edge with `res_valid`&`res_ready`; `res_valid` then falls next cycle unless PUBLISH reloads it the same cycle (load wins, no overrun).
  - `res_data`/`res_ch` are stable while `res_valid`=1 and not transferred.
- Latency, AVG_LOG2=0:
  - `start` at edge k → SELECT in cycle k+1.
  - SAMPLE occupies cycles k+2..k+1+SAMPLE_CYCLES.
  - `sar_start` high in cycle k+2+SAMPLE_CYCLES.
  - `sar_done` at edge m → `res_valid`=1 from cycle m+2.
- `busy`=1 in SELECT/SAMPLE/CONVERT/PUBLISH. Deasserting `continuous` mid-sweep finishes the current sweep.

Test Plan:
- Reset during CONVERT, then released → all outputs 0, IDLE, no `res_valid`. A subsequent `start` runs normally.
- Single sweep, mask=4'b1010, SAR model returns 0x123 (ch1), 0xABC (ch3) 10 cycles after `sar_start` → two results (ch1,0x123), (ch3,0xABC) in order. `sample_en` is 4 cycles wide; `sar_start` is exactly 1 cycle; `busy` falls after the second PUBLISH.
- AVG_LOG2=2, mask=4'b0001, results 100,101,102,103 → four `sar_start` pulses on ch0, one result 101 (406>>2).
- `continuous`=1, mask=4'b0011, `res_ready` held 0 → `overrun` sets at the second PUBLISH. `res_data` holds the newest value. Sweeps repeat until `continuous`=0, then IDLE after ch1.
- SAR model never asserts `sar_done` on ch2 (mask=4'b0111) → `timeout_err`=1 after 64 CONVERT cycles, no ch2 result; ch0 and ch1 results are delivered.
- `start` with mask=0, and `start` pulsed while busy → no state change; `busy` stays 0 / sweep unaffected.
